ov7670_capture: RTL and testbench
=================================

Name: ov7670_capture

Overview:
- Camera-side capture stage that sits directly upstream of the frame buffer. It runs in the OV7670 pixel clock domain.
- Pairs the camera's 8-bit RGB565 byte stream into 12-bit RGB444 pixels ({R[3:0],G[3:0],B[3:0]}).
- Drives the buffer's write port (data, 17-bit wraddress, wren) with a linear address computed as line*H_ACTIVE + col.
- Frames framing as whole-frame captures gated at VSYNC boundaries, and flags malformed frames.

Parameters:
H_ACTIVE, 320, pixels per line stored (QVGA).
V_ACTIVE, 240, lines per frame stored.
VSYNC_ACTIVE_HIGH, 1, 1: cam_vsync high = vertical blanking; 0: inverted.

Ports:
wr_clk  in  1  camera pixel clock (PCLK); all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
capture_en  in  1  enable; sampled only at frame start.
cam_vsync  in  1  camera VSYNC.
cam_href  in  1  camera HREF, high during active bytes.
cam_data  in  8  camera data byte.
data_out  out  12  RGB444 pixel {R,G,B}.
wraddress  out  17  buffer write address, 0..H_ACTIVE*V_ACTIVE-1.
wren  out  1  write strobe, one cycle per pixel.
frame_done  out  1  one-cycle pulse at end of each captured frame.
frame_err  out  1  one-cycle pulse coincident with frame_done if frame was malformed.
frame_count  out  8  captured-frame counter, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state WAIT_VSYNC, counters/phase/sticky error cleared. Reset mid-frame discards the partial frame. Capture resumes only after the next full vsync active->inactive sequence.
- vs_act = cam_vsync XNOR VSYNC_ACTIVE_HIGH. href_q / vs_q are one-cycle registered copies used for edge detection.
- States:
  - WAIT_VSYNC: wait for vs_act=1 -> WAIT_FRAME.
  - WAIT_FRAME: on vs_act 1->0: if capture_en=1 -> ACTIVE (line=0, col=0, phase=0, err=0); else stay in WAIT_FRAME and wait for the next vsync cycle.
  - ACTIVE: on vs_act 0->1 -> WAIT_FRAME; pulse frame_done that cycle.
- capture_en deasserted during ACTIVE has no effect until the frame ends.
- Byte pairing (ACTIVE, cam_href=1):
  - phase 0: latch byte0 = {R4..R0,G5..G3}.
  - phase 1: byte1 = {G2..G0,B4..B0}.
  - phase toggles every cycle with href high; forced to 0 whenever href is low.
- Pixel = {byte0[7:4], byte0[2:0],byte1[7], byte1[4:1]}, i.e. R[4:1], G[5:2], B[4:1].
- On the edge that samples byte1:
  - if col<H_ACTIVE and line<V_ACTIVE: in the following cycle wren=1, data_out=pixel, wraddress=line*H_ACTIVE+col (17-bit, no truncation for defaults: max 76799).
  - col increments in all cases, saturating at H_ACTIVE.
  - Latency: one clock from byte1 sample to wren high.
  - wren is otherwise 0. data_out and wraddress hold their last value.
- Out-of-range pixels (col>=H_ACTIVE or line>=V_ACTIVE) are never written and set the sticky err.
- Line end on href 1->0 (ACTIVE):
  - if col!=H_ACTIVE, set err.
  - if col>0, line increments (saturating at V_ACTIVE).
  - col and phase go to 0.
  - An odd byte count leaves an unpaired byte, which is dropped and sets err.
- Frame end (vs_act 0->1 in ACTIVE):
  - frame_done=1 for one cycle.
  - frame_err=1 the same cycle if err or line!=V_ACTIVE.
  - frame_count increments.
- A line shorter than H_ACTIVE does not shift later lines, because the address is recomputed from line/col.
- Outside ACTIVE, href activity is ignored; no wren.
- Simultaneous href fall and vsync rise: the line-end accounting is applied first, then frame-end uses the updated line count.

Test Plan:
- Full 320x240 frame, capture_en=1, cam_data byte pairs 0xF8,0x1F per pixel -> exactly 76800 wren pulses; addresses 0..76799 in order; data_out=12'hF0F; one frame_done, frame_err=0, frame_count=1.
- Reset release mid-frame (href active) -> no wren until after the next vsync active->inactive; the following frame captures normally starting at address 0.
- Line 5 has only 100 pixels -> line 6 first write at address 1920; frame_err=1 at frame_done.
- Line with 330 pixels -> 320 writes only (last address line*320+319); frame_err=1.
- capture_en=0 at frame start, raised mid-frame -> zero writes that frame; the next frame is captured; capture_en dropped mid-capture -> the current frame completes.
- 241 lines supplied -> line 240 produces no writes; frame_err=1; frame_count increments once.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 capture stage: pairs RGB565 camera bytes into RGB444 pixels and drives
// a linear frame-buffer write port, with whole-frame gating at VSYNC and error flags.
module ov7670_capture #(
  parameter int H_ACTIVE          = 320,
  parameter int V_ACTIVE          = 240,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        wr_clk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [11:0] data_out,
  output logic [16:0] wraddress,
  output logic        wren,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  frame_count
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(H_ACTIVE);
  localparam logic [LW-1:0] LINE_MAX = LW'(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    rst_pipe;
  logic          rst_sync_n;
  logic          vs_q, href_q;
  logic          phase, phase_nxt;
  logic          err, err_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [LW-1:0] line, line_nxt;
  logic [6:0]    byte0, byte0_nxt;
  logic [11:0]   data_nxt;
  logic [16:0]   addr_nxt;
  logic          wren_nxt, done_nxt, ferr_nxt;
  logic [7:0]    fcount_nxt;
  logic          vs_act, vs_rise, vs_fall, href_fall;
  logic [11:0]   pixel;
  logic [16:0]   pix_addr;

  // Reset asserts asynchronously but is released in step with wr_clk.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_pipe[1];

  assign vs_act    = cam_vsync ~^ VSYNC_ACTIVE_HIGH;
  assign vs_rise   = vs_act & ~vs_q;
  assign vs_fall   = ~vs_act & vs_q;
  assign href_fall = href_q & ~cam_href;

  // byte0 keeps only R[4:1] and G[5:3]; cam_data is the second byte here.
  assign pixel    = {byte0[6:3], byte0[2:0], cam_data[7], cam_data[4:1]};
  assign pix_addr = 17'(line) * 17'(H_ACTIVE) + 17'(col);

  // Next-state and next-output computation for the capture FSM.
  always_comb begin
    state_nxt  = state;
    line_nxt   = line;
    col_nxt    = col;
    phase_nxt  = phase;
    err_nxt    = err;
    byte0_nxt  = byte0;
    data_nxt   = data_out;
    addr_nxt   = wraddress;
    wren_nxt   = 1'b0;
    done_nxt   = 1'b0;
    ferr_nxt   = 1'b0;
    fcount_nxt = frame_count;
    case (state)
      WAIT_VSYNC: begin
        if (vs_act) begin
          state_nxt = WAIT_FRAME;
        end else begin
          state_nxt = WAIT_VSYNC;
        end
      end
      WAIT_FRAME: begin
        if (vs_fall && capture_en) begin
          state_nxt = ACTIVE;
          line_nxt  = '0;
          col_nxt   = '0;
          phase_nxt = 1'b0;
          err_nxt   = 1'b0;
        end else begin
          state_nxt = WAIT_FRAME;
        end
      end
      ACTIVE: begin
        if (cam_href) begin
          if (!phase) begin
            byte0_nxt = {cam_data[7:4], cam_data[2:0]};
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if ((col < COL_MAX) && (line < LINE_MAX)) begin
              wren_nxt = 1'b1;
              data_nxt = pixel;
              addr_nxt = pix_addr;
            end else begin
              err_nxt = 1'b1;
            end
            if (col != COL_MAX) begin
              col_nxt = col + CW'(1);
            end else begin
              col_nxt = col;
            end
          end
        end else begin
          phase_nxt = 1'b0;
          if (href_fall) begin
            // A dangling first byte (phase still 1) means an odd byte count.
            if ((col != COL_MAX) || phase) begin
              err_nxt = 1'b1;
            end else begin
              err_nxt = err;
            end
            if ((col != '0) && (line != LINE_MAX)) begin
              line_nxt = line + LW'(1);
            end else begin
              line_nxt = line;
            end
            col_nxt = '0;
          end else begin
            col_nxt = col;
          end
        end
        // Frame end sees the line accounting of this same cycle.
        if (vs_rise) begin
          state_nxt  = WAIT_FRAME;
          done_nxt   = 1'b1;
          ferr_nxt   = err_nxt | (line_nxt != LINE_MAX);
          fcount_nxt = frame_count + 8'd1;
        end else begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt = WAIT_VSYNC;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge wr_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state       <= WAIT_VSYNC;
      vs_q        <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      err         <= 1'b0;
      col         <= '0;
      line        <= '0;
      byte0       <= 7'd0;
      data_out    <= 12'd0;
      wraddress   <= 17'd0;
      wren        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      vs_q        <= vs_act;
      href_q      <= cam_href;
      phase       <= phase_nxt;
      err         <= err_nxt;
      col         <= col_nxt;
      line        <= line_nxt;
      byte0       <= byte0_nxt;
      data_out    <= data_nxt;
      wraddress   <= addr_nxt;
      wren        <= wren_nxt;
      frame_done  <= done_nxt;
      frame_err   <= ferr_nxt;
      frame_count <= fcount_nxt;
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture on a reduced 8x6 geometry, checked against
// a frame-level model that derives expected writes and frame results from line lengths.
module tb_ov7670_capture;

  localparam int H = 8;
  localparam int V = 6;

  logic        wr_clk = 1'b0;
  logic        rst_n, capture_en, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [11:0] data_out;
  logic [16:0] wraddress;
  logic        wren, frame_done, frame_err;
  logic [7:0]  frame_count;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_ACTIVE_HIGH(1'b1)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .data_out(data_out), .wraddress(wraddress),
    .wren(wren), .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct { logic [16:0] a; logic [11:0] d; } pix_t;
  typedef struct { logic e; logic [7:0] c; } res_t;

  pix_t exp_q[$];
  res_t res_q[$];
  int   lens[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_cap = 1'b0;
  bit   m_err = 1'b0;
  int   m_ln = 0;
  int   m_fc = 0;
  int   tog_ln = -1;
  bit   tog_val = 1'b0;
  int   rst_ln = -1;
  int   rst_byte = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic [7:0] b0, input logic [7:0] b1);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = b0[7:3];
    g = {b0[2:0], b1[7:5]};
    b = b1[4:0];
    return {r[4:1], g[5:2], b[4:1]};
  endfunction

  // Monitor: every write and every frame pulse is matched against the model queues.
  always @(negedge wr_clk) begin
    if (exp_q.size() == 0) begin
      check_eq("no_wren", 32'(wren), 32'd0);
    end else if (wren) begin
      pix_t p;
      p = exp_q.pop_front();
      check_eq("wraddress", 32'(wraddress), 32'(p.a));
      check_eq("data_out", 32'(data_out), 32'(p.d));
    end
    if (frame_done) begin
      if (res_q.size() == 0) begin
        check_eq("unexp_done", 32'(frame_done), 32'd0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check_eq("frame_err", 32'(frame_err), 32'(r.e));
        check_eq("frame_count", 32'(frame_count), 32'(r.c));
      end
    end else begin
      check_eq("err_no_done", 32'(frame_err), 32'd0);
    end
  end

  task automatic do_reset_mid();
    rst_n = 1'b0;
    exp_q.delete();
    res_q.delete();
    m_cap = 1'b0;
    m_err = 1'b0;
    m_ln  = 0;
    m_fc  = 0;
    repeat (2) @(posedge wr_clk);
    #1 rst_n = 1'b1;
  endtask

  // One HREF burst of nbytes, updating the frame model alongside the stimulus.
  task automatic send_line(input int nbytes, input bit fixed, input bit vs_end, input int rst_at);
    logic [7:0] b0, bt;
    int col;
    col = 0;
    b0 = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) do_reset_mid();
      if (i % 2 == 0) begin
        bt = fixed ? 8'hF8 : 8'($urandom);
        b0 = bt;
      end else begin
        bt = fixed ? 8'h1F : 8'($urandom);
        if (m_cap) begin
          if (col < H && m_ln < V) exp_q.push_back('{a: 17'(m_ln * H + col), d: exp_pix(b0, bt)});
          else m_err = 1'b1;
        end
        col++;
      end
      @(posedge wr_clk);
      #1 cam_href = 1'b1;
      cam_data = bt;
    end
    if (m_cap) begin
      if ((nbytes / 2) < H || (nbytes % 2) != 0) m_err = 1'b1;
      if ((nbytes / 2) > 0 && m_ln < V) m_ln++;
    end
    @(posedge wr_clk);
    #1 cam_href = 1'b0;
    if (vs_end) cam_vsync = 1'b1;
    else repeat (3) @(posedge wr_clk);
  endtask

  // VSYNC pulse: its rise closes the current frame, its fall opens the next.
  task automatic start_frame(input bit en);
    if (m_cap) begin
      res_q.push_back('{e: (m_err || m_ln != V), c: 8'(m_fc + 1)});
      m_fc++;
    end
    m_cap = 1'b0;
    @(posedge wr_clk);
    #1 cam_vsync = 1'b1;
    repeat (3) @(posedge wr_clk);
    #1 cam_vsync = 1'b0;
    capture_en = en;
    m_cap = en;
    m_ln  = 0;
    m_err = 1'b0;
    repeat (2) @(posedge wr_clk);
  endtask

  task automatic run_lines(input bit fixed, input bit vs_end);
    for (int l = 0; l < lens.size(); l++) begin
      if (l == tog_ln) capture_en = tog_val;
      send_line(lens[l], fixed, vs_end && (l == lens.size() - 1), (l == rst_ln) ? rst_byte : -1);
    end
    tog_ln = -1;
    rst_ln = -1;
  endtask

  task automatic full_lens(input int n);
    lens.delete();
    for (int l = 0; l < n; l++) lens.push_back(2 * H);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    capture_en = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    check_eq("rst_wren", 32'(wren), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_fcount", 32'(frame_count), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_addr", 32'(wraddress), 32'd0);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge wr_clk);

    // Full frame of constant F8/1F pixels.
    start_frame(1'b1); full_lens(V); run_lines(1'b1, 1'b0);
    // Random full frame; last HREF fall coincides with VSYNC rise.
    start_frame(1'b1); full_lens(V); run_lines(1'b0, 1'b1);
    // Short line 2, long line 4.
    start_frame(1'b1); full_lens(V); lens[2] = 6; run_lines(1'b0, 1'b0);
    start_frame(1'b1); full_lens(V); lens[4] = 2 * H + 4; run_lines(1'b0, 1'b0);
    // One extra line, then an odd byte count.
    start_frame(1'b1); full_lens(V + 1); run_lines(1'b0, 1'b0);
    start_frame(1'b1); full_lens(V); lens[3] = 2 * H - 1; run_lines(1'b0, 1'b0);
    // Disabled at frame start, raised mid-frame; then dropped mid-capture.
    start_frame(1'b0); full_lens(V); tog_ln = 2; tog_val = 1'b1; run_lines(1'b0, 1'b0);
    start_frame(1'b1); full_lens(V); tog_ln = 2; tog_val = 1'b0; run_lines(1'b0, 1'b0);
    // Reset during an active line; the next frame starts clean at address 0.
    start_frame(1'b1); full_lens(V); rst_ln = 2; rst_byte = 5; run_lines(1'b0, 1'b0);
    check_eq("fcount_after_rst", 32'(frame_count), 32'd0);
    start_frame(1'b1); full_lens(V); run_lines(1'b0, 1'b0);
    // Random line lengths.
    for (int f = 0; f < 6; f++) begin
      int nl;
      start_frame(1'b1);
      nl = V + (($urandom_range(0, 3) == 0) ? 1 : 0);
      lens.delete();
      for (int l = 0; l < nl; l++)
        lens.push_back(($urandom_range(0, 4) < 3) ? 2 * H : int'($urandom_range(1, 2 * H + 6)));
      run_lines(1'b0, ($urandom_range(0, 1) == 1));
    end
    start_frame(1'b0);
    repeat (10) @(posedge wr_clk);
    @(negedge wr_clk);
    check_eq("pix_q_left", 32'(exp_q.size()), 32'd0);
    check_eq("res_q_left", 32'(res_q.size()), 32'd0);
    check_eq("final_fcount", 32'(frame_count), 32'(8'(m_fc)));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
